// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - data-memory bus between the MEM stage controller and memory
interface mem_stage_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage: data-memory req/ack access, stall, MEM/WB register
// Optional misaligned-access squash enabled by MEM_ALIGN_CHECK_EN.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  WB,
  input  logic [2:0]  M,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WriteDataIn,
  input  logic [4:0]  RegRD,
  output logic        stall,
  mem_stage_ctrl_if.master bus,
  output logic [1:0]  WBreg,
  output logic [31:0] MemDataReg,
  output logic [31:0] ALUreg,
  output logic [4:0]  RegRDreg,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic        bus_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q;

  logic mem_op;
  logic timeout_hit;
  logic issue, complete, abort, cnt_inc, wb_pass, wb_bubble;
`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_d;
`endif

  // Branch bit belongs to the EX stage; carried through untouched here.
  wire unused_branch = M[2];

  assign mem_op      = M[1] | M[0];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    issue     = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    cnt_inc   = 1'b0;
    wb_pass   = 1'b0;
    wb_bubble = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (mem_op) begin
`ifdef MEM_ALIGN_CHECK_EN
          if (ALUOut[1:0] != 2'b00) begin
            wb_bubble  = 1'b1;
            misalign_d = 1'b1;
          end else
`endif
          begin
            stall     = 1'b1;
            issue     = 1'b1;
            wb_bubble = 1'b1;
            state_d   = ACCESS;
          end
        end else begin
          wb_pass = 1'b1;
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          complete = 1'b1;
          wb_pass  = 1'b1;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          // Squash the instruction rather than let it retire with stale data.
          abort     = 1'b1;
          wb_bubble = 1'b1;
          state_d   = IDLE;
        end else begin
          stall     = 1'b1;
          cnt_inc   = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cnt_q         <= '0;
      bus_err       <= 1'b0;
      WBreg         <= '0;
      MemDataReg    <= '0;
      ALUreg        <= '0;
      RegRDreg      <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign      <= 1'b0;
`endif
    end else begin
      if (issue) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= M[0];
        bus.mem_addr  <= ALUOut;
        bus.mem_wdata <= WriteDataIn;
        cnt_q         <= '0;
      end
      if (cnt_inc)            cnt_q       <= cnt_q + TO_W'(1);
      if (complete || abort)  bus.mem_req <= 1'b0;
      if (abort)              bus_err     <= 1'b1;
      if (wb_pass) begin
        WBreg    <= WB;
        ALUreg   <= ALUOut;
        RegRDreg <= RegRD;
      end
      if (wb_bubble) begin
        WBreg    <= '0;
        RegRDreg <= '0;
      end
      if (complete && !bus.mem_we) MemDataReg <= bus.mem_rdata;
`ifdef MEM_ALIGN_CHECK_EN
      misalign <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
  localparam int TO = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  WB;
  logic [2:0]  M;
  logic [31:0] ALUOut, WriteDataIn;
  logic [4:0]  RegRD;
  logic        stall;
  logic [1:0]  WBreg;
  logic [31:0] MemDataReg, ALUreg;
  logic [4:0]  RegRDreg;
  logic        bus_err;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Transaction-level expectation of the MEM/WB register and error flag
  logic [1:0]  exp_wb;
  logic [31:0] exp_alu, exp_mem;
  logic [4:0]  exp_rd;
  logic        exp_err;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clock(clock), .reset(reset), .WB(WB), .M(M), .ALUOut(ALUOut),
    .WriteDataIn(WriteDataIn), .RegRD(RegRD), .stall(stall), .bus(bus),
    .WBreg(WBreg), .MemDataReg(MemDataReg), .ALUreg(ALUreg), .RegRDreg(RegRDreg),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_wb(input string tag);
    tests_run++; if (WBreg !== exp_wb) begin tests_failed++; $display("FAIL %s WBreg: got %h expected %h", tag, WBreg, exp_wb); end
    tests_run++; if (ALUreg !== exp_alu) begin tests_failed++; $display("FAIL %s ALUreg: got %h expected %h", tag, ALUreg, exp_alu); end
    tests_run++; if (RegRDreg !== exp_rd) begin tests_failed++; $display("FAIL %s RegRDreg: got %h expected %h", tag, RegRDreg, exp_rd); end
    tests_run++; if (MemDataReg !== exp_mem) begin tests_failed++; $display("FAIL %s MemDataReg: got %h expected %h", tag, MemDataReg, exp_mem); end
    tests_run++; if (bus_err !== exp_err) begin tests_failed++; $display("FAIL %s bus_err: got %b expected %b", tag, bus_err, exp_err); end
    tests_run++; if (bus.mem_req !== 1'b0) begin tests_failed++; $display("FAIL %s mem_req idle: got %b expected 0", tag, bus.mem_req); end
  endtask

  // One instruction through MEM: d = ACCESS cycle (1-based) in which ack arrives
  task automatic run_instr(input string tag, input logic [1:0] wb, input logic [2:0] m,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                           input int d, input logic [31:0] rdata, input bit idle_ack);
    bit op, mis;
    int n_acc;
    op  = m[1] | m[0];
    mis = ALIGN_EN && op && (alu[1:0] != 2'b00);
    WB = wb; M = m; ALUOut = alu; WriteDataIn = wd; RegRD = rd;
    bus.mem_ack = idle_ack; bus.mem_rdata = ~rdata;
    #1;
    tests_run++; if (bus.mem_req !== 1'b0) begin tests_failed++; $display("FAIL %s idle mem_req: got %b expected 0", tag, bus.mem_req); end
    tests_run++; if (stall !== (op && !mis)) begin tests_failed++; $display("FAIL %s idle stall: got %b expected %b", tag, stall, (op && !mis)); end
    tick();
    bus.mem_ack = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    tests_run++; if (misalign !== mis) begin tests_failed++; $display("FAIL %s misalign: got %b expected %b", tag, misalign, mis); end
`endif
    if (!op || mis) begin
      if (!op) begin exp_wb = wb; exp_alu = alu; exp_rd = rd; end
      else     begin exp_wb = 2'b00; exp_rd = 5'd0; end
      check_wb(tag);
      return;
    end
    exp_wb = 2'b00; exp_rd = 5'd0;
    tests_run++; if (WBreg !== 2'b00 || RegRDreg !== 5'd0) begin tests_failed++; $display("FAIL %s issue bubble: got %h/%h expected 0/0", tag, WBreg, RegRDreg); end
    n_acc = (TO != 0 && d > TO) ? TO : d;
    for (int k = 1; k <= n_acc; k++) begin
      if (k == d) begin bus.mem_ack = 1'b1; bus.mem_rdata = rdata; end
      #1;
      tests_run++; if (bus.mem_req !== 1'b1) begin tests_failed++; $display("FAIL %s access mem_req: got %b expected 1", tag, bus.mem_req); end
      tests_run++; if (bus.mem_we !== m[0]) begin tests_failed++; $display("FAIL %s access mem_we: got %b expected %b", tag, bus.mem_we, m[0]); end
      tests_run++; if (bus.mem_addr !== alu) begin tests_failed++; $display("FAIL %s access mem_addr: got %h expected %h", tag, bus.mem_addr, alu); end
      tests_run++; if (bus.mem_wdata !== wd) begin tests_failed++; $display("FAIL %s access mem_wdata: got %h expected %h", tag, bus.mem_wdata, wd); end
      tests_run++; if (stall !== (k < n_acc)) begin tests_failed++; $display("FAIL %s access stall k=%0d: got %b expected %b", tag, k, stall, (k < n_acc)); end
      tick();
      bus.mem_ack = 1'b0;
      if (k < n_acc) begin
        tests_run++; if (WBreg !== 2'b00 || RegRDreg !== 5'd0) begin tests_failed++; $display("FAIL %s wait bubble: got %h/%h expected 0/0", tag, WBreg, RegRDreg); end
      end
    end
    if (d <= n_acc) begin
      exp_wb = wb; exp_alu = alu; exp_rd = rd;
      if (!m[0]) exp_mem = rdata;
    end else begin
      exp_err = 1'b1;
    end
    check_wb(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1; M = 3'b000; WB = 2'b00; ALUOut = '0; WriteDataIn = '0; RegRD = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    exp_wb = 2'b00; exp_alu = '0; exp_rd = '0; exp_mem = '0; exp_err = 1'b0;
    check_wb("reset");
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset stall: got %b expected 0", stall); end
    tests_run++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset bus regs: got %b/%h/%h expected 0/0/0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
`ifdef MEM_ALIGN_CHECK_EN
    tests_run++; if (misalign !== 1'b0) begin tests_failed++; $display("FAIL reset misalign: got %b expected 0", misalign); end
`endif
  endtask

  task automatic test_alu_op();
    run_instr("alu_op", 2'b10, 3'b000, 32'h0000_0040, 32'h0, 5'd8, 1, 32'h0, 1'b0);
  endtask

  task automatic test_load();
    run_instr("load", 2'b11, 3'b010, 32'h0000_0100, 32'h0, 5'd9, 3, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_store();
    run_instr("store", 2'b00, 3'b001, 32'h0000_0200, 32'h1234_5678, 5'd0, 1, 32'hCAFE_F00D, 1'b0);
    run_instr("store_rw", 2'b01, 3'b011, 32'h0000_0204, 32'hA5A5_5A5A, 5'd3, 2, 32'h1111_2222, 1'b0);
  endtask

  task automatic test_timeout();
    run_instr("timeout", 2'b11, 3'b010, 32'h0000_0300, 32'h0, 5'd12, 99, 32'h0, 1'b0);
    run_instr("ack_last", 2'b01, 3'b010, 32'h0000_0304, 32'h0, 5'd13, TO, 32'h7777_8888, 1'b0);
    run_instr("after_to", 2'b10, 3'b000, 32'h0000_0055, 32'h0, 5'd14, 1, 32'h0, 1'b0);
  endtask

  task automatic test_idle_ack();
    run_instr("idle_ack", 2'b01, 3'b100, 32'h0000_0077, 32'h0, 5'd5, 1, 32'hBAD0_BAD0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_instr("b2b_a", 2'b11, 3'b010, 32'h0000_0400, 32'h0, 5'd1, 1, 32'h0BAD_F00D, 1'b0);
    run_instr("b2b_b", 2'b11, 3'b010, 32'h0000_0404, 32'h0, 5'd2, 1, 32'h1357_9BDF, 1'b0);
    run_instr("b2b_c", 2'b01, 3'b001, 32'h0000_0408, 32'h2468_ACE0, 5'd3, 2, 32'h0, 1'b0);
  endtask

  task automatic test_misalign();
    if (ALIGN_EN)
      run_instr("misalign", 2'b11, 3'b010, 32'h0000_0102, 32'h0, 5'd6, 1, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    WB = 2'b11; M = 3'b010; ALUOut = 32'h0000_0500; WriteDataIn = '0; RegRD = 5'd7;
    tick();
    tick();
    reset = 1'b1; M = 3'b000;
    tick();
    reset = 1'b0;
    #1;
    exp_wb = 2'b00; exp_alu = '0; exp_rd = '0; exp_mem = '0; exp_err = 1'b0;
    check_wb("reset_mid");
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_mid stall: got %b expected 0", stall); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] alu;
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      run_instr("random", 2'($urandom), 3'($urandom), alu, $urandom, 5'($urandom),
                $urandom_range(1, TO + 2), $urandom, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_idle_ack();
    test_back_to_back();
    test_misalign();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
